alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one valid/ready ALU wrapper (single-entry output register, 4-bit mode, two XLEN operands) between N_REQ independent requesters.
- Round-robin arbitration on the request side.
- A tag FIFO records the requester index of every operation in flight. Each ALU result is routed back to the requester that issued it, in issue order.
- Sits between the core's functional-unit clients and the ALU wrapper.

Parameters:
- XLEN, 32, operand/result width.
- N_REQ, 3, number of requesters (2..8).
- TAG_W, 2, requester index width; must be >= clog2(N_REQ).
- DEPTH, 2, maximum outstanding operations (tag FIFO entries, power of two).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester operation valid
- req_ready  out  N_REQ  per-requester accept
- req_mode  in  4*N_REQ  ALU op code, requester i at [4i+3:4i]
- req_arg1  in  XLEN*N_REQ  operand 1, slice i
- req_arg2  in  XLEN*N_REQ  operand 2, slice i
- resp_valid  out  N_REQ  result valid, one-hot or zero
- resp_ready  in  N_REQ  per-requester result accept
- resp_result  out  XLEN  result, shared by all requesters
- alu_din_valid  out  1  to ALU
- alu_din_ready  in  1  from ALU
- alu_din_mode  out  4  to ALU
- alu_din_arg1  out  XLEN  to ALU
- alu_din_arg2  out  XLEN  to ALU
- alu_dout_valid  in  1  from ALU
- alu_dout_ready  out  1  to ALU
- alu_dout_result  in  XLEN  from ALU
- outstanding  out  TAG_W+1  ops in flight (tag FIFO count)
- proto_err  out  1  sticky: ALU result arrived with empty tag FIFO

Behaviour:
- Reset is sync on clock. While reset is high, all outputs are forced low: req_ready, alu_din_valid, resp_valid, alu_dout_ready.
- Registered state and reset values: rr_ptr=0, count=0, FIFO rd/wr pointers=0, proto_err=0.
- Arbitration (combinational):
  - grant = first i with req_valid[i], searching cyclically from rr_ptr.
  - alu_din_valid = |req_valid && count<DEPTH.
  - alu_din_mode/arg1/arg2 = slices of the granted requester; don't-care when nothing is granted.
  - req_ready[i] = grant[i] && alu_din_ready && count<DEPTH.
  - At most one bit of req_ready is high.
- Issue handshake (alu_din_valid && alu_din_ready):
  - push grant index into the tag FIFO;
  - rr_ptr <= (index+1) mod N_REQ, with the wrap computed explicitly for non-power-of-two N_REQ.
  - rr_ptr does not change without a handshake.
- Requesters hold valid and operands stable until accepted. The grant may move to a different requester only when rr_ptr moves, or when a requester earlier in the cyclic order becomes valid.
- Response routing:
  - head = tag at FIFO read pointer.
  - resp_valid[head] = alu_dout_valid && count>0; all other resp_valid bits are 0.
  - resp_result = alu_dout_result.
  - alu_dout_ready = resp_ready[head] && count>0.
- On response handshake (alu_dout_valid && alu_dout_ready): pop the tag FIFO.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Issue is allowed when count==DEPTH only if… it is not: the full check uses the registered count, so there is no same-cycle bypass.
- Full (count==DEPTH): no issue; all req_ready=0; alu_din_valid=0.
- Empty (count==0) with alu_dout_valid=1:
  - proto_err <= 1 (sticky until reset);
  - alu_dout_ready=0;
  - no resp_valid asserted.
- Latency: request accepted in cycle T → ALU registers it → resp_valid in T+1 at the earliest. Results return strictly in issue order.
- Reset mid-operation: in-flight tags are discarded. The ALU is reset from the same reset, so no stale results return.

Test Plan:
- Single op, N_REQ=3. Req1 issues mode=0 (ADD), arg1=5, arg2=7, resp_ready all 1 → req_ready[1] same cycle; next cycle resp_valid=3'b010, resp_result=12; outstanding 1→0.
- Round robin. All three requesters hold valid continuously with ADD of distinct operands; resp_ready=1 → grants in order 0,1,2,0,1,2; one issue per cycle; each response appears on the matching resp_valid bit one cycle later.
- Backpressure and full.
  - Stimulus: req0 SUB (mode=10) 9-4, resp_ready[0]=0 for 4 cycles.
  - ALU output register stalls and alu_din_ready drops; the second request stays blocked. outstanding never exceeds DEPTH=2 and no req_ready is given while count==2.
  - Release resp_ready → results 5 and then the second result, in order.
- Simultaneous push/pop. Steady stream at 1 op/cycle with resp_ready=1 → outstanding constant at 1; no lost or duplicated tags across 20 ops (scoreboard compare).
- Signed compare routing. Req2 issues SLT (mode=12) arg1=0xFFFFFFFF, arg2=1 → resp_valid=3'b100, resp_result=1. Req0 issues SLTU (mode=14) with the same operands → result 0 on resp_valid=3'b001.
- Reset and error.
  - Assert reset with 2 ops in flight → next cycle outstanding=0, all valid/ready outputs 0, rr_ptr restarts at requester 0.
  - Force alu_dout_valid=1 with the FIFO empty → proto_err=1 and stays set until reset.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one valid/ready ALU.
// A tag FIFO remembers who issued each in-flight op so results go back in issue order.
module alu_share_arbiter #(
  parameter int XLEN  = 32,
  parameter int N_REQ = 3,
  parameter int TAG_W = 2,
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_mode,
  input  logic [XLEN*N_REQ-1:0] req_arg1,
  input  logic [XLEN*N_REQ-1:0] req_arg2,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [XLEN-1:0]       resp_result,
  output logic                  alu_din_valid,
  input  logic                  alu_din_ready,
  output logic [3:0]            alu_din_mode,
  output logic [XLEN-1:0]       alu_din_arg1,
  output logic [XLEN-1:0]       alu_din_arg2,
  input  logic                  alu_dout_valid,
  output logic                  alu_dout_ready,
  input  logic [XLEN-1:0]       alu_dout_result,
  output logic [TAG_W:0]        outstanding,
  output logic                  proto_err
);

  localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [TAG_W-1:0] LAST_REQ   = TAG_W'(N_REQ - 1);

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_any;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W:0]   count;
  logic [TAG_W-1:0] head;
  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             head_ready;

  assign not_full    = (count < FULL_COUNT);
  assign not_empty   = (count != '0);
  assign head        = tag_mem[rd_ptr];
  assign outstanding = count;
  assign resp_result = alu_dout_result;

  // Cyclic search starting at rr_ptr: offset k maps to requester (rr_ptr + k) mod N_REQ.
  always_comb begin
    int target;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    target    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      target = int'(rr_ptr) + k;
      if (target >= N_REQ) target = target - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_any && (i == target) && req_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = TAG_W'(i);
        end
      end
    end
  end

  always_comb begin
    alu_din_mode = '0;
    alu_din_arg1 = '0;
    alu_din_arg2 = '0;
    req_ready    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        alu_din_mode = req_mode[4*i +: 4];
        alu_din_arg1 = req_arg1[XLEN*i +: XLEN];
        alu_din_arg2 = req_arg2[XLEN*i +: XLEN];
        req_ready[i] = grant_any && alu_din_ready && not_full && !reset;
      end
    end
  end

  assign alu_din_valid = grant_any && not_full && !reset;

  // Responses belong to the requester at the FIFO head; nothing is routed while it is empty.
  always_comb begin
    resp_valid = '0;
    head_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head == TAG_W'(i)) begin
        resp_valid[i] = alu_dout_valid && not_empty && !reset;
        head_ready    = resp_ready[i];
      end
    end
  end

  assign alu_dout_ready = head_ready && not_empty && !reset;
  assign push           = alu_din_valid && alu_din_ready;
  assign pop            = alu_dout_valid && alu_dout_ready;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (alu_dout_valid && !not_empty) proto_err <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; entries are only read between a push and its pop.
  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small single-entry ALU stub;
// the stub can be bypassed so the bench drives the ALU handshake directly.
module tb_alu_share_arbiter;

  localparam int XLEN  = 32;
  localparam int N_REQ = 3;
  localparam int TAG_W = 2;
  localparam int DEPTH = 2;

  logic                  clock;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [4*N_REQ-1:0]    req_mode;
  logic [XLEN*N_REQ-1:0] req_arg1;
  logic [XLEN*N_REQ-1:0] req_arg2;
  logic [N_REQ-1:0]      resp_valid;
  logic [N_REQ-1:0]      resp_ready;
  logic [XLEN-1:0]       resp_result;
  logic                  alu_din_valid;
  logic                  alu_din_ready;
  logic [3:0]            alu_din_mode;
  logic [XLEN-1:0]       alu_din_arg1;
  logic [XLEN-1:0]       alu_din_arg2;
  logic                  alu_dout_valid;
  logic                  alu_dout_ready;
  logic [XLEN-1:0]       alu_dout_result;
  logic [TAG_W:0]        outstanding;
  logic                  proto_err;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(
    .XLEN(XLEN), .N_REQ(N_REQ), .TAG_W(TAG_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_arg1(req_arg1), .req_arg2(req_arg2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .alu_din_valid(alu_din_valid), .alu_din_ready(alu_din_ready),
    .alu_din_mode(alu_din_mode), .alu_din_arg1(alu_din_arg1), .alu_din_arg2(alu_din_arg2),
    .alu_dout_valid(alu_dout_valid), .alu_dout_ready(alu_dout_ready),
    .alu_dout_result(alu_dout_result),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU stub: one output register, accepts new input when empty or draining.
  logic            alu_manual;
  logic            m_din_ready;
  logic            m_dout_valid;
  logic [XLEN-1:0] m_dout_result;
  logic            stub_valid;
  logic [XLEN-1:0] stub_result;
  logic            stub_din_ready;

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] m,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    case (m)
      4'd0:    return a + b;
      4'd10:   return a - b;
      4'd12:   return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd14:   return {{(XLEN-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  assign stub_din_ready  = !stub_valid || alu_dout_ready;
  assign alu_din_ready   = alu_manual ? m_din_ready   : stub_din_ready;
  assign alu_dout_valid  = alu_manual ? m_dout_valid  : stub_valid;
  assign alu_dout_result = alu_manual ? m_dout_result : stub_result;

  always_ff @(posedge clock) begin
    if (reset) begin
      stub_valid  <= 1'b0;
      stub_result <= '0;
    end else if (!alu_manual) begin
      if (alu_din_valid && stub_din_ready) begin
        stub_valid  <= 1'b1;
        stub_result <= alu_op(alu_din_mode, alu_din_arg1, alu_din_arg2);
      end else if (alu_dout_ready) begin
        stub_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] m,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_mode[4*i +: 4]       = m;
    req_arg1[XLEN*i +: XLEN] = a;
    req_arg2[XLEN*i +: XLEN] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [XLEN-1:0] exp_rr [N_REQ];
    int              exp_idx_q [$];
    logic [XLEN-1:0] exp_res_q [$];
    int              e_idx;
    logic [XLEN-1:0] e_res;

    reset         = 1'b1;
    req_valid     = 3'b111;
    resp_ready    = '0;
    req_mode      = '0;
    req_arg1      = '0;
    req_arg2      = '0;
    alu_manual    = 1'b0;
    m_din_ready   = 1'b0;
    m_dout_valid  = 1'b0;
    m_dout_result = '0;

    // Reset state: outputs held low even with requests pending.
    tick();
    tick();
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_din_valid", alu_din_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_dout_ready", alu_dout_ready, 0);
    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = 3'b111;

    // Round robin: all three valid, grants 0,1,2,0,1,2 with responses one cycle behind.
    set_req(0, 4'd0, 32'd3, 32'd4);
    set_req(1, 4'd0, 32'd20, 32'd22);
    set_req(2, 4'd0, 32'd100, 32'd200);
    exp_rr[0] = 32'd7;
    exp_rr[1] = 32'd42;
    exp_rr[2] = 32'd300;
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_grant", req_ready, 64'd1 << (c % 3));
      if (c > 0) begin
        check("rr_resp_valid", resp_valid, 64'd1 << ((c - 1) % 3));
        check("rr_resp_result", resp_result, exp_rr[(c - 1) % 3]);
        check("rr_outstanding", outstanding, 1);
      end
      tick();
    end
    req_valid = '0;
    #1;
    check("rr_last_valid", resp_valid, 3'b100);
    check("rr_last_result", resp_result, 300);
    tick();
    #1;
    check("rr_drained", outstanding, 0);
    check("rr_idle_valid", resp_valid, 0);

    // Single op: requester 1 adds 5+7.
    set_req(1, 4'd0, 32'd5, 32'd7);
    req_valid = 3'b010;
    #1;
    check("single_req_ready", req_ready, 3'b010);
    check("single_din_valid", alu_din_valid, 1);
    check("single_din_mode", alu_din_mode, 0);
    check("single_din_arg1", alu_din_arg1, 5);
    check("single_din_arg2", alu_din_arg2, 7);
    check("single_out_before", outstanding, 0);
    tick();
    req_valid = '0;
    #1;
    check("single_resp_valid", resp_valid, 3'b010);
    check("single_resp_result", resp_result, 12);
    check("single_out_during", outstanding, 1);
    tick();
    #1;
    check("single_out_after", outstanding, 0);
    check("single_resp_idle", resp_valid, 0);

    // Backpressure: req0 SUB 9-4 stalls on resp_ready[0]=0, req1 ADD 1+2 must wait.
    set_req(0, 4'd10, 32'd9, 32'd4);
    set_req(1, 4'd0, 32'd1, 32'd2);
    req_valid  = 3'b011;
    resp_ready = 3'b110;
    #1;
    check("bp_first_grant", req_ready, 3'b001);
    tick();
    req_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_din_ready", alu_din_ready, 0);
      check("bp_req_blocked", req_ready, 0);
      check("bp_resp_valid", resp_valid, 3'b001);
      check("bp_resp_result", resp_result, 5);
      check("bp_dout_ready", alu_dout_ready, 0);
      check("bp_outstanding", outstanding, 1);
      tick();
    end
    resp_ready = 3'b111;
    #1;
    check("bp_release_dout", alu_dout_ready, 1);
    check("bp_second_grant", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    check("bp_second_valid", resp_valid, 3'b010);
    check("bp_second_result", resp_result, 3);
    check("bp_second_out", outstanding, 1);
    tick();
    #1;
    check("bp_drained", outstanding, 0);

    // Signed vs unsigned compare routed to different requesters.
    set_req(2, 4'd12, 32'hFFFF_FFFF, 32'd1);
    req_valid = 3'b100;
    #1;
    check("slt_grant", req_ready, 3'b100);
    tick();
    req_valid = '0;
    #1;
    check("slt_resp_valid", resp_valid, 3'b100);
    check("slt_resp_result", resp_result, 1);
    tick();
    set_req(0, 4'd14, 32'hFFFF_FFFF, 32'd1);
    req_valid = 3'b001;
    #1;
    check("sltu_grant", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    check("sltu_resp_valid", resp_valid, 3'b001);
    check("sltu_resp_result", resp_result, 0);
    tick();

    // Stream of 20 ops, one per cycle, scoreboarded in issue order.
    for (int k = 0; k < 20; k++) begin
      set_req(k % 3, 4'd0, XLEN'(k * 3), XLEN'(k + 100));
      req_valid = N_REQ'(1 << (k % 3));
      #1;
      check("stream_grant", req_ready, 64'd1 << (k % 3));
      if (k > 0) begin
        e_idx = exp_idx_q.pop_front();
        e_res = exp_res_q.pop_front();
        check("stream_resp_valid", resp_valid, 64'd1 << e_idx);
        check("stream_resp_result", resp_result, e_res);
        check("stream_outstanding", outstanding, 1);
      end
      exp_idx_q.push_back(k % 3);
      exp_res_q.push_back(XLEN'(4 * k + 100));
      tick();
    end
    req_valid = '0;
    #1;
    e_idx = exp_idx_q.pop_front();
    e_res = exp_res_q.pop_front();
    check("stream_last_valid", resp_valid, 64'd1 << e_idx);
    check("stream_last_result", resp_result, e_res);
    tick();
    #1;
    check("stream_drained", outstanding, 0);

    // Full: ALU driven by hand, accepts two ops and returns nothing.
    alu_manual   = 1'b1;
    m_din_ready  = 1'b1;
    m_dout_valid = 1'b0;
    req_valid    = 3'b111;
    #1;
    check("full_grant_a", req_ready, 3'b100);
    tick();
    #1;
    check("full_grant_b", req_ready, 3'b001);
    check("full_out_one", outstanding, 1);
    tick();
    #1;
    check("full_outstanding", outstanding, 2);
    check("full_req_ready", req_ready, 0);
    check("full_din_valid", alu_din_valid, 0);

    // Reset with two ops in flight.
    reset        = 1'b1;
    m_dout_valid = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 0);
    check("midrst_din_valid", alu_din_valid, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_dout_ready", alu_dout_ready, 0);
    tick();
    #1;
    check("midrst_outstanding", outstanding, 0);
    reset        = 1'b0;
    m_dout_valid = 1'b0;
    #1;
    check("midrst_rr_restart", req_ready, 3'b001);
    check("midrst_din_valid_on", alu_din_valid, 1);
    req_valid = '0;

    // Result with an empty tag FIFO.
    m_dout_valid  = 1'b1;
    m_dout_result = 32'hDEAD;
    #1;
    check("perr_dout_ready", alu_dout_ready, 0);
    check("perr_resp_valid", resp_valid, 0);
    check("perr_before", proto_err, 0);
    tick();
    #1;
    check("perr_set", proto_err, 1);
    m_dout_valid = 1'b0;
    tick();
    tick();
    #1;
    check("perr_sticky", proto_err, 1);
    check("perr_outstanding", outstanding, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("perr_cleared", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
